control_unit: RTL and testbench
===============================

# control_unit

Multicycle sequencer for the MIPS-subset datapath. It takes the decoded instruction fields and ALU flags and drives every datapath control line through fetch, decode, execute, memory and write-back. It also sequences the invalid-opcode and overflow exception paths. It sits beside the datapath in the `cpu` top level, and its outputs connect one-to-one to the datapath control wires of the same name.

## Interface
- No parameters; all encodings are fixed below.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0].
- Overflow, Zero  in  1 each  ALU flags (combinational, current cycle).
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA, EPCWrite, IorD  out  1 each.
- AluSrcB  out  4  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- ALUControl  out  3  000=pass A, 001=add, 010=sub, 011=and.
- PCSource  out  4  0=ALUResult, 1=ALUout, 2=jump target, 4=exception vector.
- Exception  out  4  0=none, 1=invalid opcode, 2=overflow.
- ShiftControl  out  3  tied 000 (no shift instructions in this subset).
- State  out  6  current state code, for debug/bench.

## Operation
- Supported instructions:
  - R-type (OPCODE 0x00): add 0x20, sub 0x22, and 0x24, jr 0x08.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
  - Anything else, including an unknown FUNCT, is invalid.
- Outputs are Moore-decoded from State, except PCwrite in BRANCH. Every output is 0 unless listed for the state below.
- FETCH0, FETCH1: IorD=0. FETCH2: IorD=0, IRWrite=1, AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1 (PC←PC+4).
- DECODE: AluSrcA=0, AluSrcB=3, ALUControl=001 (ALUout←branch target). Next state:
  - EX_R for add/sub/and; JR for jr; EX_I for addi; ADDR for lw/sw; BRANCH for beq/bne; JUMP for j.
  - EXC_EPC with code 1 otherwise.
- EX_R: AluSrcA=1, AluSrcB=0, ALUControl per FUNCT. If Overflow=1 on add/sub, go to EXC_EPC with code 2; else go to WB_R.
- WB_R: RegWrite=1, RegDest=1, MemToReg=0.
- EX_I: AluSrcA=1, AluSrcB=2, ALUControl=001. If Overflow=1, go to EXC_EPC with code 2; else go to WB_I.
- WB_I: RegWrite=1, RegDest=0, MemToReg=0.
- ADDR: AluSrcA=1, AluSrcB=2, ALUControl=001. Next is MR0 for lw, SW for sw.
- MR0, MR1, MR2: IorD=1, with ALU held at AluSrcA=1, AluSrcB=2, 001 so that the always-loaded ALUout stays at the address. MR2 also asserts MemRead=1 (MDR load).
- WB_L: RegWrite=1, RegDest=0, MemToReg=1.
- SW: IorD=1, MemWrite=1, ALU held as in ADDR.
- BRANCH: AluSrcA=1, AluSrcB=0, ALUControl=010, PCSource=1. PCwrite=Zero for beq, PCwrite=~Zero for bne.
- JR: AluSrcA=1, ALUControl=000, PCSource=0, PCwrite=1.
- JUMP: PCSource=2, PCwrite=1.
- EXC_EPC: AluSrcA=0, AluSrcB=1, ALUControl=010 (ALUout←PC−4, the faulting address).
- EXC_SAVE: EPCWrite=1, PCSource=4, PCwrite=1.
- Exception output: driven from an internal code register, latched on entry to EXC_EPC and held through EXC_SAVE; 0 in all other states.
- WB_R, WB_I, WB_L, SW, BRANCH, JR, JUMP and EXC_SAVE all return to FETCH0.

## Timing
- Reset: reset=1 at a rising edge puts State in FETCH0 and clears the code register.
  - While reset is high, every output is forced to 0 combinationally, including mid-instruction. No register or memory write occurs in a reset cycle.
- Memory read latency: the address is held 3 cycles, and data is captured (IR or MDR) in the third cycle.
- Cycles per instruction, FETCH0 to the next FETCH0:
  - add/sub/and/addi/sw: 6.
  - lw: 9.
  - beq/bne/j/jr: 5.
  - Invalid opcode: 6 (F0–F2, DECODE, EXC_EPC, EXC_SAVE).
  - Overflow: 7.
- Overflow is sampled only in EX_R (add/sub) and EX_I. An overflow suppresses the write-back: RegWrite is never asserted for a faulting instruction.
- An and instruction never raises an overflow exception, even if the Overflow flag is high.
- Zero is sampled only in BRANCH. A not-taken branch leaves PC at PC+4.

## Test plan
- Reset held 2 cycles during MR1 of an lw → every output is 0 during reset; State=FETCH0 on the cycle after release; no MemRead or RegWrite pulse occurs.
- OPCODE=0x00, FUNCT=0x20, Overflow=0 → IRWrite and PCwrite in cycle 3, RegWrite=1 with RegDest=1 in cycle 6, back in FETCH0 at cycle 7.
- OPCODE=0x23 → IorD=1 for 3 cycles, MemRead=1 in MR2 only, RegWrite=1 with MemToReg=1 in cycle 9.
- OPCODE=0x04 with Zero=1, then with Zero=0 → PCwrite=1 with PCSource=1 in BRANCH, then PCwrite=0; both take 5 cycles.
- OPCODE=0x08 with Overflow=1 in EX_I → no RegWrite; EXC_EPC shows ALUControl=010; EXC_SAVE shows EPCWrite=1, PCSource=4, Exception=2.
- OPCODE=0x3F → DECODE goes to EXC_EPC; EXC_SAVE shows Exception=1; back in FETCH0 after 6 cycles.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle sequencer for the MIPS-subset datapath.
//
// Walks fetch / decode / execute / memory / write-back for the supported
// instructions and sequences the invalid-opcode and overflow exception paths.
// Outputs are decoded from the current state (Moore). The one exception is
// PCwrite in BRANCH, which follows Zero for beq and ~Zero for bne.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   OPCODE, FUNCT     IR[31:26], IR[5:0]
//   Overflow, Zero    ALU flags (combinational, current cycle)
//   PCwrite .. IorD   single-bit datapath controls
//   AluSrcB           0=B, 1=4, 2=sext imm, 3=sext imm<<2
//   ALUControl        000=pass A, 001=add, 010=sub, 011=and
//   PCSource          0=ALUResult, 1=ALUout, 2=jump target, 4=exception vector
//   Exception         0=none, 1=invalid opcode, 2=overflow
//   ShiftControl      always 000
//   State             current state code (debug)
//
// While reset is high every output, State included, is forced to 0 so that
// no register or memory write can happen during a reset cycle.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic       EPCWrite,
    output logic       IorD,
    output logic [3:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [3:0] PCSource,
    output logic [3:0] Exception,
    output logic [2:0] ShiftControl,
    output logic [5:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] EXC_NONE    = 4'd0;
    localparam logic [3:0] EXC_INVALID = 4'd1;
    localparam logic [3:0] EXC_OVF     = 4'd2;

    typedef enum logic [5:0] {
        S_FETCH0   = 6'd0,
        S_FETCH1   = 6'd1,
        S_FETCH2   = 6'd2,
        S_DECODE   = 6'd3,
        S_EX_R     = 6'd4,
        S_WB_R     = 6'd5,
        S_EX_I     = 6'd6,
        S_WB_I     = 6'd7,
        S_ADDR     = 6'd8,
        S_MR0      = 6'd9,
        S_MR1      = 6'd10,
        S_MR2      = 6'd11,
        S_WB_L     = 6'd12,
        S_SW       = 6'd13,
        S_BRANCH   = 6'd14,
        S_JR       = 6'd15,
        S_JUMP     = 6'd16,
        S_EXC_EPC  = 6'd17,
        S_EXC_SAVE = 6'd18
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH0;
            code_q  <= EXC_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Next state; the exception code is captured on the transition into EXC_EPC.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXC_EPC;
                code_d  = EXC_INVALID;
                case (OPCODE)
                    OP_RTYPE: begin
                        if (FUNCT == FN_ADD || FUNCT == FN_SUB || FUNCT == FN_AND) begin
                            state_d = S_EX_R;
                            code_d  = code_q;
                        end else if (FUNCT == FN_JR) begin
                            state_d = S_JR;
                            code_d  = code_q;
                        end
                    end
                    OP_ADDI:        begin state_d = S_EX_I;   code_d = code_q; end
                    OP_LW, OP_SW:   begin state_d = S_ADDR;   code_d = code_q; end
                    OP_BEQ, OP_BNE: begin state_d = S_BRANCH; code_d = code_q; end
                    OP_J:           begin state_d = S_JUMP;   code_d = code_q; end
                    default: ;
                endcase
            end
            S_EX_R: begin
                // and cannot overflow, so the flag is ignored for it.
                if (Overflow && FUNCT != FN_AND) begin
                    state_d = S_EXC_EPC;
                    code_d  = EXC_OVF;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_EX_I: begin
                if (Overflow) begin
                    state_d = S_EXC_EPC;
                    code_d  = EXC_OVF;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_ADDR:    state_d = (OPCODE == OP_LW) ? S_MR0 : S_SW;
            S_MR0:     state_d = S_MR1;
            S_MR1:     state_d = S_MR2;
            S_MR2:     state_d = S_WB_L;
            S_EXC_EPC: state_d = S_EXC_SAVE;
            default:   state_d = S_FETCH0;
        endcase
    end

    // Output decode; defaults first, then per-state overrides, then reset gating.
    always_comb begin
        PCwrite      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        RegDest      = 1'b0;
        AluSrcA      = 1'b0;
        EPCWrite     = 1'b0;
        IorD         = 1'b0;
        AluSrcB      = 4'd0;
        ALUControl   = 3'b000;
        PCSource     = 4'd0;
        Exception    = EXC_NONE;
        ShiftControl = 3'b000;
        State        = state_q;
        case (state_q)
            S_FETCH2: begin
                IRWrite = 1'b1; AluSrcB = 4'd1; ALUControl = 3'b001; PCwrite = 1'b1;
            end
            S_DECODE: begin
                AluSrcB = 4'd3; ALUControl = 3'b001;
            end
            S_EX_R: begin
                AluSrcA = 1'b1;
                case (FUNCT)
                    FN_ADD:  ALUControl = 3'b001;
                    FN_SUB:  ALUControl = 3'b010;
                    FN_AND:  ALUControl = 3'b011;
                    default: ALUControl = 3'b000;
                endcase
            end
            S_WB_R: begin RegWrite = 1'b1; RegDest = 1'b1; end
            S_WB_I: RegWrite = 1'b1;
            // Address computation is held through the memory states so the
            // always-loaded ALUout keeps presenting the address.
            S_EX_I, S_ADDR: begin
                AluSrcA = 1'b1; AluSrcB = 4'd2; ALUControl = 3'b001;
            end
            S_MR0, S_MR1, S_MR2: begin
                IorD = 1'b1; AluSrcA = 1'b1; AluSrcB = 4'd2; ALUControl = 3'b001;
                MemRead = (state_q == S_MR2);
            end
            S_WB_L: begin RegWrite = 1'b1; MemToReg = 1'b1; end
            S_SW: begin
                IorD = 1'b1; MemWrite = 1'b1;
                AluSrcA = 1'b1; AluSrcB = 4'd2; ALUControl = 3'b001;
            end
            S_BRANCH: begin
                AluSrcA = 1'b1; ALUControl = 3'b010; PCSource = 4'd1;
                PCwrite = (OPCODE == OP_BEQ) ? Zero : ~Zero;
            end
            S_JR: begin AluSrcA = 1'b1; PCwrite = 1'b1; end
            S_JUMP: begin PCSource = 4'd2; PCwrite = 1'b1; end
            S_EXC_EPC: begin
                AluSrcB = 4'd1; ALUControl = 3'b010; Exception = code_q;
            end
            S_EXC_SAVE: begin
                EPCWrite = 1'b1; PCSource = 4'd4; PCwrite = 1'b1; Exception = code_q;
            end
            default: ;
        endcase
        if (reset) begin
            PCwrite    = 1'b0; MemWrite = 1'b0; MemRead  = 1'b0; IRWrite  = 1'b0;
            RegWrite   = 1'b0; MemToReg = 1'b0; RegDest  = 1'b0; AluSrcA  = 1'b0;
            EPCWrite   = 1'b0; IorD     = 1'b0; AluSrcB  = 4'd0;
            ALUControl = 3'b000; PCSource = 4'd0; Exception = EXC_NONE;
            State      = 6'd0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit. A per-instruction model lists the control word
// every cycle of an instruction must show; a negedge compare process checks
// the DUT against that list, and all-zero outputs while reset is high.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OPCODE = 6'd0;
    logic [5:0] FUNCT = 6'd0;
    logic       Overflow = 1'b0;
    logic       Zero = 1'b0;
    logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg;
    logic       RegDest, AluSrcA, EPCWrite, IorD;
    logic [3:0] AluSrcB, PCSource, Exception;
    logic [2:0] ALUControl, ShiftControl;
    logic [5:0] State;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [27:0] exp_q[$];
    logic [27:0] dut_v;

    control_unit dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .Zero(Zero),
        .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .RegDest(RegDest), .AluSrcA(AluSrcA), .EPCWrite(EPCWrite), .IorD(IorD),
        .AluSrcB(AluSrcB), .ALUControl(ALUControl), .PCSource(PCSource),
        .Exception(Exception), .ShiftControl(ShiftControl), .State(State)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign dut_v = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg,
                    RegDest, AluSrcA, EPCWrite, IorD, AluSrcB, ALUControl,
                    PCSource, Exception, ShiftControl};

    function automatic logic [27:0] vec(
        input logic pcw, mw, mr, irw, rw, m2r, rd, asa, epcw, iord,
        input logic [3:0] asb, input logic [2:0] aluc,
        input logic [3:0] pcs, input logic [3:0] exc);
        return {pcw, mw, mr, irw, rw, m2r, rd, asa, epcw, iord, asb, aluc, pcs, exc, 3'b000};
    endfunction

    // Reference model: the control word each cycle of one instruction must carry.
    task automatic model(input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, input logic zr, output logic [27:0] q[$]);
        logic [27:0] hold;
        logic [2:0]  aluc;
        logic [3:0]  code;
        logic        fault;
        q.delete();
        fault = 1'b0;
        code  = 4'd0;
        hold  = vec(0,0,0,0,0,0,0,1,0,0, 4'd2, 3'b001, 4'd0, 4'd0);
        q.push_back('0);
        q.push_back('0);
        q.push_back(vec(1,0,0,1,0,0,0,0,0,0, 4'd1, 3'b001, 4'd0, 4'd0));
        q.push_back(vec(0,0,0,0,0,0,0,0,0,0, 4'd3, 3'b001, 4'd0, 4'd0));
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            aluc = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            q.push_back(vec(0,0,0,0,0,0,0,1,0,0, 4'd0, aluc, 4'd0, 4'd0));
            if (ovf && fn != 6'h24) begin fault = 1'b1; code = 4'd2; end
            else q.push_back(vec(0,0,0,0,1,0,1,0,0,0, 4'd0, 3'b000, 4'd0, 4'd0));
        end else if (op == 6'h00 && fn == 6'h08) begin
            q.push_back(vec(1,0,0,0,0,0,0,1,0,0, 4'd0, 3'b000, 4'd0, 4'd0));
        end else if (op == 6'h08) begin
            q.push_back(hold);
            if (ovf) begin fault = 1'b1; code = 4'd2; end
            else q.push_back(vec(0,0,0,0,1,0,0,0,0,0, 4'd0, 3'b000, 4'd0, 4'd0));
        end else if (op == 6'h23) begin
            q.push_back(hold);
            for (int i = 0; i < 3; i++)
                q.push_back(hold | vec(0,0,(i == 2),0,0,0,0,0,0,1, 4'd0, 3'b000, 4'd0, 4'd0));
            q.push_back(vec(0,0,0,0,1,1,0,0,0,0, 4'd0, 3'b000, 4'd0, 4'd0));
        end else if (op == 6'h2B) begin
            q.push_back(hold);
            q.push_back(hold | vec(0,1,0,0,0,0,0,0,0,1, 4'd0, 3'b000, 4'd0, 4'd0));
        end else if (op == 6'h04 || op == 6'h05) begin
            q.push_back(vec((op == 6'h04) ? zr : !zr, 0,0,0,0,0,0,1,0,0,
                            4'd0, 3'b010, 4'd1, 4'd0));
        end else if (op == 6'h02) begin
            q.push_back(vec(1,0,0,0,0,0,0,0,0,0, 4'd0, 3'b000, 4'd2, 4'd0));
        end else begin
            fault = 1'b1; code = 4'd1;
        end
        if (fault) begin
            q.push_back(vec(0,0,0,0,0,0,0,0,0,0, 4'd1, 3'b010, 4'd0, code));
            q.push_back(vec(1,0,0,0,0,0,0,0,1,0, 4'd0, 3'b000, 4'd4, code));
        end
    endtask

    // Scoreboard: model pins first, then one compare per falling edge.
    task automatic pin(input string name, input logic [27:0] act, input logic [27:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        logic [27:0] q[$];
        logic [27:0] e;
        model(6'h00, 6'h20, 1'b0, 1'b0, q);
        pin("model_add_len", 28'(q.size()), 28'd6);
        pin("model_fetch2", q[2], 28'h9004800);
        pin("model_add_wb", q[5], 28'h0A00000);
        model(6'h23, 6'h00, 1'b0, 1'b0, q);
        pin("model_lw_len", 28'(q.size()), 28'd9);
        pin("model_lw_mr2", q[7], 28'h2148800);
        model(6'h3F, 6'h00, 1'b0, 1'b0, q);
        pin("model_inv_len", 28'(q.size()), 28'd6);
        pin("model_inv_save", q[5], 28'h8080208);
        model(6'h04, 6'h00, 1'b0, 1'b1, q);
        pin("model_beq_len", 28'(q.size()), 28'd5);
        pin("model_beq_taken", q[4], 28'h8101080);
        model(6'h08, 6'h00, 1'b1, 1'b0, q);
        pin("model_addi_ovf_len", 28'(q.size()), 28'd7);
        forever begin
            @(negedge clk);
            if (reset) begin
                pin("reset_outputs", dut_v, 28'h0);
                pin("reset_state", 28'(State), 28'h0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_v !== e) begin
                    errors++;
                    $display("FAIL ctrl_word cycle %0d op=%h fn=%h: got %h expected %h",
                             cycle, OPCODE, FUNCT, dut_v, e);
                end
            end
        end
    end

    // Driver: queue the expected words, present the instruction, let it run.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic zr);
        logic [27:0] q[$];
        model(op, fn, ovf, zr, q);
        foreach (q[i]) exp_q.push_back(q[i]);
        OPCODE = op; FUNCT = fn; Overflow = ovf; Zero = zr;
        repeat (q.size()) @(posedge clk);
        #1;
    endtask

    task automatic lw_with_reset();
        logic [27:0] q[$];
        model(6'h23, 6'h00, 1'b0, 1'b0, q);
        foreach (q[i]) exp_q.push_back(q[i]);
        OPCODE = 6'h23; FUNCT = 6'h00; Overflow = 1'b0; Zero = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] op, fn;
        int         k;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'h00, 6'h20, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0);
        run_instr(6'h04, 6'h00, 1'b0, 1'b1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0);
        run_instr(6'h08, 6'h00, 1'b1, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        lw_with_reset();
        run_instr(6'h00, 6'h24, 1'b1, 1'b0);
        run_instr(6'h00, 6'h22, 1'b1, 1'b0);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0);
        run_instr(6'h00, 6'h08, 1'b0, 1'b0);
        run_instr(6'h00, 6'h21, 1'b0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 11);
            op = 6'h00;
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h08;
                4: op = 6'h08;
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h04;
                8: op = 6'h05;
                9: op = 6'h02;
                10: op = 6'($urandom_range(0, 63));
                default: ;
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
